spi_slv_regs: RTL and testbench
===============================

Name: spi_slv_regs

Overview:
- SPI slave register bank that sits at the far end of the SPI bus driven by the SoC SPI master; consumes sck/cs_n/mosi and produces miso.
- Serves as an on-chip loopback target for the SPI controller and as a generic SPI-accessible configuration block.
- Local side exposes a combinational register read port and a write-event strobe to the rest of the SoC.
- All SPI inputs are oversampled in the clk_i domain; there is no SPI-clocked logic.

Parameters:
- ADDR_W, 4, register address width (1..5); DEPTH = 2^ADDR_W 8-bit registers.
- ID_VAL, 8'hA5, constant value returned by register 0, which is read-only.

Ports:
- clk_i  input  1  system clock; must be at least 8x the SCK frequency.
- rst_i  input  1  synchronous reset, active-high.
- sck_i  input  1  SPI clock from master (mode 0: CPOL=0, CPHA=0).
- cs_ni  input  1  SPI chip select, active-low.
- mosi_i  input  1  SPI data from master, MSB first.
- miso_o  output  1  SPI data to master, MSB first.
- loc_addr_i  input  ADDR_W  local read address.
- loc_rdata_o  output  8  combinational read of reg[loc_addr_i]; address 0 returns ID_VAL.
- wr_stb_o  output  1  one-cycle pulse for each SPI register write.
- wr_addr_o  output  ADDR_W  address of the last SPI write.
- wr_data_o  output  8  data of the last SPI write.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - all registers = 0; state IDLE; bit counter = 0; address = 0.
  - miso_o = 0, wr_stb_o = 0, wr_addr_o = 0, wr_data_o = 0.
  - synchronizer flops: sck = 0, cs_n = 1, mosi = 0.
  - Reset mid-frame aborts the frame; the slave resynchronises only on the next falling edge of cs_n.
- Synchronisation and edge detection:
  - sck_i, cs_ni and mosi_i each pass through a 2-flop synchronizer.
  - Rise and fall are detected by comparing the synced sck against a third delayed flop.
  - Edge-detect strobes are single-cycle.
- Frame format:
  - Byte 0 is the command: bit7 = 1 read, 0 write; bits[6:ADDR_W] ignored; bits[ADDR_W-1:0] = start address.
  - Bytes 1..n are data; the address auto-increments after every data byte and wraps DEPTH-1 -> 0.
- FSM:
  - IDLE: go to CMD when synced cs_n = 0.
  - CMD: after 8 rise edges, latch rw and address. For a read, load tx_sr with reg[addr]. Go to DATA.
  - DATA, write mode: on the 8th rise edge:
    - reg[addr] <= rx byte, unless addr = 0, in which case the write is ignored and no strobe is issued;
    - next cycle wr_stb_o = 1 for 1 cycle, with wr_addr_o and wr_data_o updated in the same cycle;
    - addr++.
  - DATA, read mode: on the 8th rise edge, addr++ and tx_sr <= reg[addr+1] (wrapped).
  - Any state: synced cs_n = 1 -> IDLE. A partial byte is discarded with no write and no strobe. The bit counter clears.
- Shift rules:
  - rx shift register samples synced mosi on each rise edge, MSB first.
  - On each fall edge while cs_n = 0: miso_o <= tx_sr[7]; tx_sr <<= 1.
  - tx_sr holds 0 during CMD and during write frames, so miso_o = 0 there.
  - While cs_n = 1, miso_o = 0.
- Simultaneous events:
  - cs_n rising in the same cycle as a rise edge completing byte 8: the cs_n deassertion wins; that byte is not committed.
  - Local reads are combinational and always see the register state of the current cycle; an SPI write is visible on the clock after commit.
- The bit counter is 3 bits and wraps naturally; the byte boundary is count = 7 at a rise edge.

Test Plan:
- Reset then idle -> miso_o=0, wr_stb_o=0, loc_rdata_o at address 3 = 8'h00, at address 0 = 8'hA5.
- SPI write cmd 8'h03, data 8'h5C, 8'h7E -> two wr_stb_o pulses, (3,5C) then (4,7E); loc_rdata_o at 3 = 5C, at 4 = 7E.
- SPI read cmd 8'h83, two data bytes clocked -> master receives 8'h5C then 8'h7E on miso.
- Write cmd 8'h0F, data 11, 22 -> address 15 = 11; second write targets address 0, is ignored with no strobe; address 0 still reads A5.
- Write cmd 8'h05, then cs_n raised after 5 data bits -> no strobe; address 5 unchanged at 00.
- rst_i asserted mid-read at bit 3 of the data byte -> miso_o=0 next cycle; the next full frame (read 8'h80) returns A5.

Source files
------------

// File: rtl/spi_slv_regs.sv
// SPI slave register bank (mode 0, MSB first), oversampled in the clk_i domain.
// Byte 0 is the command (bit7 = read, low ADDR_W bits = start address); the
// following bytes are data with an auto-incrementing, wrapping address.
// Register 0 is a read-only ID; the local side has a combinational read port
// and a write-event strobe.
module spi_slv_regs #(
    parameter int         ADDR_W = 4,
    parameter logic [7:0] ID_VAL = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sck_i,
    input  logic              cs_ni,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic [ADDR_W-1:0] loc_addr_i,
    output logic [7:0]        loc_rdata_o,
    output logic              wr_stb_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    // Synchronizer stages; sck has a third stage for edge detection.
    logic              sck_p0, sck_p1, sck_p2;
    logic              cs_p0, cs_p1;
    logic              mosi_p0, mosi_p1;

    // flush[1] is set once cs_p1 holds a real sample rather than its reset value.
    logic [1:0]        flush;
    // Set only after a genuine high level on cs_n, so a frame interrupted by
    // reset is not picked up halfway; the next cs_n fall starts cleanly.
    logic              armed;

    logic              sck_rise, sck_fall, byte_done;
    state_t            state;
    logic [2:0]        bit_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        rx_byte;
    logic [7:0]        tx_sr;
    logic              rw;
    logic [ADDR_W-1:0] addr, cmd_addr, next_addr;
    logic [7:0]        regs [DEPTH];

    // Register read with the read-only ID at address 0.
    function automatic logic [7:0] rd_reg(input logic [ADDR_W-1:0] a);
        if (a == '0)
            return ID_VAL;
        else
            return regs[a];
    endfunction

    assign sck_rise  = sck_p1 & ~sck_p2;
    assign sck_fall  = ~sck_p1 & sck_p2;
    assign rx_byte   = {rx_sr, mosi_p1};
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign cmd_addr  = rx_byte[ADDR_W-1:0];
    assign next_addr = addr + 1'b1;

    // Two-flop synchronizers for the SPI pins plus the delayed sck for edge detect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
            flush   <= 2'b00;
        end else begin
            sck_p0  <= sck_i;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            cs_p0   <= cs_ni;
            cs_p1   <= cs_p0;
            mosi_p0 <= mosi_i;
            mosi_p1 <= mosi_p0;
            flush   <= {flush[0], 1'b1};
        end
    end

    // Frame FSM, shift registers, register file and write-event outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            armed     <= 1'b0;
            bit_cnt   <= 3'd0;
            rx_sr     <= 7'd0;
            tx_sr     <= 8'h00;
            rw        <= 1'b0;
            addr      <= '0;
            miso_o    <= 1'b0;
            wr_stb_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= 8'h00;
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
        end else begin
            wr_stb_o <= 1'b0;
            if (cs_p1) begin
                // Deselect wins over everything, including a byte completing now.
                state   <= IDLE;
                bit_cnt <= 3'd0;
                tx_sr   <= 8'h00;
                miso_o  <= 1'b0;
                if (flush[1]) armed <= 1'b1;
            end else begin
                if (state != IDLE) begin
                    if (sck_rise) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (sck_fall) begin
                        miso_o <= tx_sr[7];
                        tx_sr  <= {tx_sr[6:0], 1'b0};
                    end
                end
                case (state)
                    IDLE: begin
                        if (armed) begin
                            state   <= CMD;
                            bit_cnt <= 3'd0;
                            tx_sr   <= 8'h00;
                        end
                    end
                    CMD: begin
                        if (byte_done) begin
                            rw    <= rx_byte[7];
                            addr  <= cmd_addr;
                            tx_sr <= rx_byte[7] ? rd_reg(cmd_addr) : 8'h00;
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (byte_done) begin
                            addr <= next_addr;
                            if (rw) begin
                                tx_sr <= rd_reg(next_addr);
                            end else if (addr != '0) begin
                                regs[addr] <= rx_byte;
                                wr_stb_o   <= 1'b1;
                                wr_addr_o  <= addr;
                                wr_data_o  <= rx_byte;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Local read port sees the current register contents combinationally.
    always_comb begin
        loc_rdata_o = rd_reg(loc_addr_i);
    end

endmodule

// File: tb/tb_spi_slv_regs.sv
// Directed bench for spi_slv_regs: drives mode-0 SPI frames as a master and
// checks miso data, write strobes and the local read port.
module tb_spi_slv_regs;

    localparam int HALF = 8;  // clk cycles per SCK half period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_rdata;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int total = 0;
    int bad = 0;

    logic [3:0] stb_a [$];
    logic [7:0] stb_d [$];
    int         miso_hi = 0;

    spi_slv_regs #(.ADDR_W(4), .ID_VAL(8'hA5)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sck_i       (sck),
        .cs_ni       (cs_n),
        .mosi_i      (mosi),
        .miso_o      (miso),
        .loc_addr_i  (loc_addr),
        .loc_rdata_o (loc_rdata),
        .wr_stb_o    (wr_stb),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data)
    );

    always #5 clk = ~clk;

    // Record every write strobe and every cycle miso is high.
    always @(negedge clk) begin
        if (wr_stb) begin
            stb_a.push_back(wr_addr);
            stb_d.push_back(wr_data);
        end
        if (miso) miso_hi++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            rx[7-i] = miso;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(2*HALF);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(4);
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", miso); end
        total++; if (wr_stb !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b want=0", wr_stb); end
        total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL reset_wr_addr got=%h want=0", wr_addr); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h want=00", wr_data); end
        loc_addr = 4'd3; #1;
        total++; if (loc_rdata !== 8'h00) begin bad++; $display("FAIL reset_loc3 got=%h want=00", loc_rdata); end
        loc_addr = 4'd0; #1;
        total++; if (loc_rdata !== 8'hA5) begin bad++; $display("FAIL reset_loc0 got=%h want=a5", loc_rdata); end
    endtask

    task automatic test_write();
        logic [7:0] rx;
        int s0 = stb_a.size();
        int m0 = miso_hi;
        frame_begin();
        spi_xfer(8'h03, 8, rx);
        spi_xfer(8'h5C, 8, rx);
        spi_xfer(8'h7E, 8, rx);
        frame_end();
        total++; if (stb_a.size() - s0 != 2) begin bad++; $display("FAIL write_stb_count got=%0d want=2", stb_a.size() - s0); end
        if (stb_a.size() - s0 == 2) begin
            total++; if (stb_a[s0] !== 4'd3 || stb_d[s0] !== 8'h5C) begin bad++; $display("FAIL write_stb0 got=(%h,%h) want=(3,5c)", stb_a[s0], stb_d[s0]); end
            total++; if (stb_a[s0+1] !== 4'd4 || stb_d[s0+1] !== 8'h7E) begin bad++; $display("FAIL write_stb1 got=(%h,%h) want=(4,7e)", stb_a[s0+1], stb_d[s0+1]); end
        end
        total++; if (wr_addr !== 4'd4 || wr_data !== 8'h7E) begin bad++; $display("FAIL write_last got=(%h,%h) want=(4,7e)", wr_addr, wr_data); end
        total++; if (miso_hi != m0) begin bad++; $display("FAIL write_miso_quiet got=%0d want=0 high cycles", miso_hi - m0); end
        loc_addr = 4'd3; #1;
        total++; if (loc_rdata !== 8'h5C) begin bad++; $display("FAIL write_loc3 got=%h want=5c", loc_rdata); end
        loc_addr = 4'd4; #1;
        total++; if (loc_rdata !== 8'h7E) begin bad++; $display("FAIL write_loc4 got=%h want=7e", loc_rdata); end
    endtask

    task automatic test_read();
        logic [7:0] r0, r1, r2;
        int s0 = stb_a.size();
        frame_begin();
        spi_xfer(8'h83, 8, r0);
        spi_xfer(8'h00, 8, r1);
        spi_xfer(8'h00, 8, r2);
        frame_end();
        total++; if (r0 !== 8'h00) begin bad++; $display("FAIL read_cmd_miso got=%h want=00", r0); end
        total++; if (r1 !== 8'h5C) begin bad++; $display("FAIL read_byte0 got=%h want=5c", r1); end
        total++; if (r2 !== 8'h7E) begin bad++; $display("FAIL read_byte1 got=%h want=7e", r2); end
        total++; if (stb_a.size() != s0) begin bad++; $display("FAIL read_no_stb got=%0d want=0", stb_a.size() - s0); end
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL read_miso_idle got=%b want=0", miso); end
    endtask

    task automatic test_wrap_id();
        logic [7:0] rx, r1, r2;
        int s0 = stb_a.size();
        frame_begin();
        spi_xfer(8'h0F, 8, rx);
        spi_xfer(8'h11, 8, rx);
        spi_xfer(8'h22, 8, rx);
        frame_end();
        total++; if (stb_a.size() - s0 != 1) begin bad++; $display("FAIL wrap_stb_count got=%0d want=1", stb_a.size() - s0); end
        if (stb_a.size() - s0 == 1) begin
            total++; if (stb_a[s0] !== 4'd15 || stb_d[s0] !== 8'h11) begin bad++; $display("FAIL wrap_stb0 got=(%h,%h) want=(f,11)", stb_a[s0], stb_d[s0]); end
        end
        total++; if (wr_addr !== 4'd15 || wr_data !== 8'h11) begin bad++; $display("FAIL wrap_last got=(%h,%h) want=(f,11)", wr_addr, wr_data); end
        loc_addr = 4'd15; #1;
        total++; if (loc_rdata !== 8'h11) begin bad++; $display("FAIL wrap_loc15 got=%h want=11", loc_rdata); end
        loc_addr = 4'd0; #1;
        total++; if (loc_rdata !== 8'hA5) begin bad++; $display("FAIL wrap_loc0 got=%h want=a5", loc_rdata); end
        // Read across the wrap: address 15 then address 0 (the ID).
        frame_begin();
        spi_xfer(8'h8F, 8, rx);
        spi_xfer(8'h00, 8, r1);
        spi_xfer(8'h00, 8, r2);
        frame_end();
        total++; if (r1 !== 8'h11) begin bad++; $display("FAIL wrap_read15 got=%h want=11", r1); end
        total++; if (r2 !== 8'hA5) begin bad++; $display("FAIL wrap_read0 got=%h want=a5", r2); end
    endtask

    task automatic test_partial();
        logic [7:0] rx;
        int s0 = stb_a.size();
        frame_begin();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'hFF, 5, rx);
        frame_end();
        total++; if (stb_a.size() != s0) begin bad++; $display("FAIL partial_no_stb got=%0d want=0", stb_a.size() - s0); end
        loc_addr = 4'd5; #1;
        total++; if (loc_rdata !== 8'h00) begin bad++; $display("FAIL partial_loc5 got=%h want=00", loc_rdata); end
        // A complete frame afterwards must be byte-aligned again.
        frame_begin();
        spi_xfer(8'h05, 8, rx);
        spi_xfer(8'h3C, 8, rx);
        frame_end();
        total++; if (stb_a.size() - s0 != 1) begin bad++; $display("FAIL partial_next_count got=%0d want=1", stb_a.size() - s0); end
        if (stb_a.size() - s0 == 1) begin
            total++; if (stb_a[s0] !== 4'd5 || stb_d[s0] !== 8'h3C) begin bad++; $display("FAIL partial_next_stb got=(%h,%h) want=(5,3c)", stb_a[s0], stb_d[s0]); end
        end
        #1;
        total++; if (loc_rdata !== 8'h3C) begin bad++; $display("FAIL partial_next_loc5 got=%h want=3c", loc_rdata); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        frame_begin();
        spi_xfer(8'h83, 8, rx);
        spi_xfer(8'h00, 4, rx);
        wait_clk(6);
        // Reg 3 holds 5C, so bit 3 (a one) is on miso now.
        total++; if (miso !== 1'b1) begin bad++; $display("FAIL midrst_pre_miso got=%b want=1", miso); end
        rst = 1'b1;
        wait_clk(1);
        total++; if (miso !== 1'b0) begin bad++; $display("FAIL midrst_miso got=%b want=0", miso); end
        rst = 1'b0;
        wait_clk(4);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(2*HALF);
        loc_addr = 4'd3; #1;
        total++; if (loc_rdata !== 8'h00) begin bad++; $display("FAIL midrst_loc3 got=%h want=00", loc_rdata); end
        total++; if (wr_addr !== 4'd0 || wr_data !== 8'h00) begin bad++; $display("FAIL midrst_wr got=(%h,%h) want=(0,00)", wr_addr, wr_data); end
        frame_begin();
        spi_xfer(8'h80, 8, rx);
        spi_xfer(8'h00, 8, rx);
        frame_end();
        total++; if (rx !== 8'hA5) begin bad++; $display("FAIL midrst_read_id got=%h want=a5", rx); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrap_id();
        test_partial();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
